// File: rtl/matrix_encoder_pkg.sv
// Shared types and default geometry for the matrix-encoder sequencing controller.
package matrix_encoder_pkg;

    localparam int LINE_W      = 25;
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_ROUNDS  = 24;
    localparam int DEF_RND_W   = 5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        STEP,
        WRITE,
        DONE
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic rd_en;
        logic step_en;
        logic wr_en;
    } ctrl_outs_t;

    // Moore strobes for a given state; registered alongside the state itself.
    function automatic ctrl_outs_t state_outs(state_e s);
        ctrl_outs_t o;
        o         = '0;
        o.busy    = (s != IDLE);
        o.done    = (s == DONE);
        o.rd_en   = (s == READ);
        o.step_en = (s == STEP);
        o.wr_en   = (s == WRITE);
        return o;
    endfunction

endpackage

// File: rtl/matrix_encoder_ctrl_if.sv
// Handshake and datapath-control bundle between the block host and the encoder controller.
interface matrix_encoder_ctrl_if
    import matrix_encoder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RND_W  = DEF_RND_W
);

    logic              start;
    logic [ADDR_W:0]   num_lines;
    logic              abort;
    logic              rd_valid;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              ld_line;
    logic              step_en;
    logic [RND_W-1:0]  round_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output start, num_lines, abort, rd_valid, wr_ready,
        input  busy, done, rd_en, rd_addr, ld_line, step_en, round_idx, wr_en, wr_addr
    );

    modport slave (
        input  start, num_lines, abort, rd_valid, wr_ready,
        output busy, done, rd_en, rd_addr, ld_line, step_en, round_idx, wr_en, wr_addr
    );

endinterface

// File: rtl/matrix_encoder_ctrl_round_counter.sv
// Permutation round counter: clear has priority over enable, tc flags the final round.
module round_counter
    import matrix_encoder_pkg::*;
#(
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int RND_W  = DEF_RND_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [RND_W-1:0] count,
    output logic             tc
);

    localparam logic [RND_W-1:0] LAST = RND_W'(ROUNDS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + RND_W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/matrix_encoder_ctrl.sv
// Walks a block of matrix lines: read, load, ROUNDS permutation steps, write back.
//   state | meaning
//   IDLE  | waiting for start; all outputs low
//   READ  | one-cycle read request for the current line
//   WAIT  | waiting for rd_valid; line register loads in that cycle
//   STEP  | one permutation round per cycle
//   WRITE | write request held until wr_ready
//   DONE  | one-cycle completion pulse
module matrix_encoder_ctrl
    import matrix_encoder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ROUNDS = DEF_ROUNDS,
    parameter int RND_W  = DEF_RND_W
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_encoder_ctrl_if.slave bus
);

    state_e            state;
    ctrl_outs_t        outs;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   lines_q;
    logic [RND_W-1:0]  round;
    logic              round_tc;
    logic              round_clr;
    logic              round_en;
    logic              last_line;

    // Compare against the full-width count so a block of 2^ADDR_W lines ends at all-ones.
    assign last_line = (({1'b0, addr} + (ADDR_W+1)'(1)) == lines_q);

    // Counter only runs in STEP; anything else (including abort) parks it at zero.
    assign round_en  = (state == STEP);
    assign round_clr = (state != STEP) || round_tc || bus.abort;

    round_counter #(
        .ROUNDS (ROUNDS),
        .RND_W  (RND_W)
    ) u_round_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (round_clr),
        .en    (round_en),
        .count (round),
        .tc    (round_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            outs    <= '0;
            addr    <= '0;
            lines_q <= '0;
        end else if (bus.abort && (state != IDLE)) begin
            state <= IDLE;
            outs  <= state_outs(IDLE);
            addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr <= '0;
                        if (bus.num_lines == '0) begin
                            state <= DONE;
                            outs  <= state_outs(DONE);
                        end else begin
                            lines_q <= bus.num_lines;
                            state   <= READ;
                            outs    <= state_outs(READ);
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                    outs  <= state_outs(WAIT);
                end
                WAIT: begin
                    if (bus.rd_valid) begin
                        state <= STEP;
                        outs  <= state_outs(STEP);
                    end
                end
                STEP: begin
                    if (round_tc) begin
                        state <= WRITE;
                        outs  <= state_outs(WRITE);
                    end
                end
                WRITE: begin
                    if (bus.wr_ready) begin
                        if (last_line) begin
                            state <= DONE;
                            outs  <= state_outs(DONE);
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= READ;
                            outs  <= state_outs(READ);
                        end
                    end
                end
                DONE: begin
                    addr  <= '0;
                    state <= IDLE;
                    outs  <= state_outs(IDLE);
                end
                default: begin
                    addr  <= '0;
                    state <= IDLE;
                    outs  <= state_outs(IDLE);
                end
            endcase
        end
    end

    assign bus.busy      = outs.busy;
    assign bus.done      = outs.done;
    assign bus.rd_en     = outs.rd_en;
    assign bus.step_en   = outs.step_en;
    assign bus.wr_en     = outs.wr_en;
    assign bus.ld_line   = (state == WAIT) && bus.rd_valid;
    assign bus.rd_addr   = addr;
    assign bus.wr_addr   = addr;
    assign bus.round_idx = round;

endmodule

// File: doc/matrix_encoder_ctrl.md
# matrix_encoder_ctrl

Sequencing controller for the matrix-encoder datapath. It walks a block of 25-bit matrix lines held in the line memory. For each line it:
- issues a read,
- loads the line register,
- applies the permutation step for a fixed number of rounds,
- writes the result back to the same address.

It sits between the top-level start/done handshake and the datapath register, permutation stage and memory ports. It owns no data bits itself.

## Interface
Parameters:
- ADDR_W, 6, line-memory address width (64 lines)
- ROUNDS, 24, permutation rounds applied per line (≥1)
- RND_W, 5, width of round index (must hold ROUNDS-1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request to process a block; sampled only in IDLE
- num_lines  in  ADDR_W+1  line count 0..2^ADDR_W, latched on accepted start
- abort  in  1  stop current block at next edge
- rd_valid  in  1  read data on datapath bus is valid this cycle
- wr_ready  in  1  memory accepts write this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, block completed
- rd_en  out  1  read request, one cycle per line
- rd_addr  out  ADDR_W  read address
- ld_line  out  1  load line register from read bus
- step_en  out  1  apply one permutation round to line register
- round_idx  out  RND_W  current round number
- wr_en  out  1  write request, held until accepted
- wr_addr  out  ADDR_W  write address (= current line address)

## Operation
- States: IDLE, READ, WAIT, STEP, WRITE, DONE.
- IDLE:
  - start & num_lines≠0 → latch num_lines, addr←0 → READ.
  - start & num_lines=0 → DONE, no memory traffic.
- READ: rd_en=1, rd_addr=addr, exactly one cycle → WAIT.
- WAIT: hold until rd_valid.
  - In the rd_valid cycle, ld_line=1 combinationally, round←0 → STEP.
  - rd_valid in any other state is ignored.
- STEP: step_en=1 and round_idx=round every cycle. round increments each cycle. When round=ROUNDS-1 → WRITE.
- WRITE: wr_en=1, wr_addr=addr, held until wr_en&wr_ready. Then:
  - addr=num_lines-1 → DONE;
  - otherwise addr←addr+1 → READ.
- DONE: done=1 for one cycle → IDLE.
- start while busy is ignored. num_lines changes after acceptance have no effect.
- abort in any non-IDLE state → IDLE at next edge. The current write is not issued and done is not pulsed. abort has priority over all other transitions. It is a no-op in IDLE.
- rst: state←IDLE, addr←0, round←0.
- Outputs in IDLE/after reset: all 0 (busy, done, rd_en, ld_line, step_en, wr_en, rd_addr, wr_addr, round_idx).
- num_lines=2^ADDR_W: addr ends at all-ones with no wrap, then DONE.
- rd_addr and wr_addr show addr in every state; they are only meaningful with their strobes.

## Timing
- Moore outputs except ld_line, which is WAIT & rd_valid.
- Cycle 0: start accepted. Cycle 1: READ.
- Per line, with read latency L (rd_valid in the L-th WAIT cycle) and write stall S: 1 + L + ROUNDS + 1 + S cycles.
- L=1, S=0, ROUNDS=24: 27 cycles per line. done is high in cycle 1+27·N. Next start is accepted in cycle 2+27·N.
- num_lines=0: done in cycle 1.
- step_en is high for exactly ROUNDS consecutive cycles per line, round_idx 0..ROUNDS-1 in order.
- There is never more than one outstanding read. rd_en is never asserted while wr_en is high.

## Structure
- Package matrix_encoder_pkg:
  - state enum (IDLE, READ, WAIT, STEP, WRITE, DONE);
  - LINE_W=25, default ADDR_W, ROUNDS, RND_W constants.
- One sub-module, round_counter: up-counter with synchronous clear, enable and terminal-count flag at ROUNDS-1. It drives round_idx and the STEP→WRITE transition.
- The address counter and FSM stay inline.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0. start with num_lines=0 → done in cycle 1, no rd_en, step_en or wr_en.
- num_lines=2, rd_valid one cycle after rd_en, wr_ready=1:
  - rd_en at cycles 1 and 28 (addr 0, 1);
  - step_en in cycles 3–26 and 30–53, round_idx 0..23;
  - wr_en at cycles 27 and 54;
  - done at 55.
- num_lines=1, rd_valid delayed 4 cycles, wr_ready low for 3 cycles → WAIT lasts 4 cycles, ld_line only in the 4th, wr_en held 4 cycles at addr 0, done at cycle 34.
- Pulse start again during a num_lines=3 run and change num_lines to 1 → ignored; exactly 3 writes (addr 0, 1, 2).
- abort in cycle 10 (STEP, line 0) → IDLE at cycle 11, busy=0, no wr_en, no done. A new start with num_lines=1 then completes normally.
- num_lines=64 with ROUNDS=2 → 64 writes to addr 0..63 in order, no wrap to 0, single done pulse. Assert rst mid-block → outputs 0 on next cycle.
